// File: rtl/shared_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shared_bus_arbiter
//  Description : Round-robin single-owner arbiter that muxes one of N
//                requesters onto a valid/ready bus, with stall timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_bus_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_STALL = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    gnt,
    output logic [DW-1:0]   bus_data,
    output logic            bus_valid,
    output logic            bus_last,
    input  logic            bus_ready,
    output logic            timeout
);
    localparam int c_IW = (N > 1) ? $clog2(N) : 1;
    localparam int c_SW = c_IW + 1;
    localparam int c_CW = $clog2(MAX_STALL);
    localparam logic [c_CW-1:0] c_STALL_LIM = c_CW'(MAX_STALL - 1);
    localparam logic [c_SW-1:0] c_N         = c_SW'(N);
    localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t          r_state, w_next_state;
    logic [c_IW-1:0] r_owner, w_next_owner;
    logic [c_IW-1:0] r_ptr, w_next_ptr;
    logic [c_CW-1:0] r_stall, w_next_stall;
    logic [N-1:0]    r_gnt, w_next_gnt;
    logic            r_timeout, w_next_timeout;

    logic [DW-1:0]   w_data_arr [N];
    logic [c_IW-1:0] w_pick;
    logic [c_SW-1:0] w_sum;
    logic [c_IW-1:0] w_sel;
    logic [c_IW-1:0] w_owner_inc;
    logic            w_granted;
    logic            w_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign w_data_arr[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // Output mux is driven only from the registered owner, so a non-owner never reaches the bus.
    assign w_granted = (r_state == S_GRANT);
    assign bus_valid = w_granted & req[r_owner];
    assign bus_data  = w_granted ? w_data_arr[r_owner] : '0;
    assign bus_last  = bus_valid & req_last[r_owner];
    assign w_xfer    = bus_valid & bus_ready;
    assign gnt       = r_gnt;
    assign timeout   = r_timeout;

    assign w_owner_inc = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;

    // Descending scan so the candidate closest to r_ptr is written last and wins.
    always_comb begin
        w_pick = '0;
        w_sum  = '0;
        w_sel  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + c_SW'(k);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_sel = w_sum[c_IW-1:0];
            if (req[w_sel]) begin
                w_pick = w_sel;
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_owner   = r_owner;
        w_next_ptr     = r_ptr;
        w_next_stall   = r_stall;
        w_next_gnt     = r_gnt;
        w_next_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_next_state       = S_GRANT;
                    w_next_owner       = w_pick;
                    w_next_gnt         = '0;
                    w_next_gnt[w_pick] = 1'b1;
                    w_next_stall       = '0;
                end
            end
            S_GRANT: begin
                if (!req[r_owner] || (w_xfer && req_last[r_owner])) begin
                    w_next_state = S_RELEASE;
                    w_next_gnt   = '0;
                    w_next_stall = '0;
                end else if (w_xfer) begin
                    w_next_stall = '0;
                end else if (r_stall == c_STALL_LIM) begin
                    w_next_state   = S_RELEASE;
                    w_next_gnt     = '0;
                    w_next_stall   = '0;
                    w_next_timeout = 1'b1;
                end else begin
                    w_next_stall = r_stall + 1'b1;
                end
            end
            S_RELEASE: begin
                w_next_state = S_IDLE;
                w_next_ptr   = w_owner_inc;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_gnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_stall   <= '0;
            r_gnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_owner   <= w_next_owner;
            r_ptr     <= w_next_ptr;
            r_stall   <= w_next_stall;
            r_gnt     <= w_next_gnt;
            r_timeout <= w_next_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shared_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shared_bus_arbiter
//  Description : Scoreboard bench for shared_bus_arbiter with packet producers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_bus_arbiter;
    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int MAX_STALL = 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   bus_data;
    logic            bus_valid;
    logic            bus_last;
    logic            bus_ready;
    logic            timeout;

    shared_bus_arbiter #(.N(N), .DW(DW), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
        .gnt(gnt), .bus_data(bus_data), .bus_valid(bus_valid), .bus_last(bus_last),
        .bus_ready(bus_ready), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic          valid;
        logic [DW-1:0] data;
        logic          last;
        logic          to;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int            rem  [N];
    int            plen [N];
    int            beat [N];
    logic [DW-1:0] base [N];
    logic [N-1:0]  xfer_cap;

    int            glog[$];
    logic [DW-1:0] dlog[$];
    int            to_cnt = 0;
    logic [N-1:0]  prev_gnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // ---------------- reference model: owner/bubble/pointer bookkeeping ----------------
    int m_owner  = -1;
    int m_rel    = 0;
    bit m_bubble = 0;
    int m_ptr    = 0;
    int m_stall  = 0;
    bit m_to     = 0;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : model
        exp_t e;
        bit   nt;
        bit   xf;
        e  = '0;
        nt = 0;
        if (!rst_n) begin
            m_owner = -1; m_bubble = 0; m_ptr = 0; m_stall = 0; m_to = 0;
        end else begin
            if (m_owner >= 0) begin
                e.gnt[m_owner] = 1'b1;
                e.valid = req[m_owner];
                e.data  = req_data[m_owner*DW +: DW];
                e.last  = req[m_owner] & req_last[m_owner];
            end
            e.to = m_to;
            if (m_bubble) begin
                m_ptr    = (m_rel + 1) % N;
                m_bubble = 0;
            end else if (m_owner < 0) begin
                m_owner = rr_pick(m_ptr, req);
                m_stall = 0;
            end else begin
                xf = e.valid & bus_ready;
                if (!e.valid || (xf && e.last) || (!xf && m_stall == MAX_STALL - 1)) begin
                    nt       = e.valid && !xf;
                    m_rel    = m_owner;
                    m_owner  = -1;
                    m_bubble = 1;
                end else if (xf) begin
                    m_stall = 0;
                end else begin
                    m_stall++;
                end
            end
            m_to = nt;
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor: pops one expectation per presented output cycle ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: no expectation at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("bus_valid", 32'(bus_valid), 32'(e.valid));
            chk("bus_data", 32'(bus_data), 32'(e.data));
            chk("bus_last", 32'(bus_last), 32'(e.last));
            chk("timeout", 32'(timeout), 32'(e.to));
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        end
        if (gnt != '0 && prev_gnt == '0) begin
            for (int k = 0; k < N; k++) if (gnt[k]) glog.push_back(k);
        end
        if (bus_valid && bus_ready) dlog.push_back(bus_data);
        if (timeout) to_cnt++;
        prev_gnt = gnt;
    end

    always @(negedge clk) xfer_cap = gnt & {N{bus_valid & bus_ready}};

    // ---------------- producers ----------------
    initial begin
        req = '0; req_data = '0; req_last = '0; prev_gnt = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; plen[i] = 1; beat[i] = 0; base[i] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (xfer_cap[i] && rem[i] > 0) begin
                    rem[i]--;
                    beat[i]++;
                end
                req[i]               = (rem[i] > 0);
                req_data[i*DW +: DW] = base[i] + DW'(beat[i]);
                req_last[i]          = (rem[i] > 0) && ((rem[i] - 1) % plen[i] == 0);
            end
        end
    end

    task automatic load(input int i, input int pl, input int npk, input logic [DW-1:0] b);
        plen[i] = pl; rem[i] = pl * npk; beat[i] = 0; base[i] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) if (rem[i] != 0) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input int budget);
        int quiet = 0;
        for (int c = 0; c < budget && quiet < 3; c++) begin
            tick();
            if (all_done() && gnt == '0) quiet++; else quiet = 0;
        end
        total++;
        if (quiet < 3) begin
            bad++;
            $display("FAIL idle_wait: quiet=%0d needed 3 within %0d cycles", quiet, budget);
        end
    endtask

    task automatic wait_dlog(input int target, input int budget);
        int c = 0;
        while (dlog.size() < target && c < budget) begin
            tick();
            c++;
        end
        chk("dlog_wait", 32'(dlog.size() >= target), 32'd1);
    endtask

    // ---------------- directed tests then random ----------------
    initial begin
        int g0, d0, t0;
        int stall_left;
        rst_n = 1'b0;
        bus_ready = 1'b1;
        load(0, 1, 2, 8'h10);
        load(1, 1, 1, 8'h20);
        load(2, 1, 1, 8'h30);
        load(3, 1, 1, 8'h40);
        repeat (3) tick();
        chk("reset_req", 32'(req), 32'hF);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_valid", 32'(bus_valid), 32'h0);
        chk("reset_data", 32'(bus_data), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        wait_idle(200);
        chk("rr_count", 32'(glog.size()), 32'd5);
        chk("rr_0", 32'(glog[0]), 32'd0);
        chk("rr_1", 32'(glog[1]), 32'd1);
        chk("rr_2", 32'(glog[2]), 32'd2);
        chk("rr_3", 32'(glog[3]), 32'd3);
        chk("rr_4", 32'(glog[4]), 32'd0);

        // single requester, three beats
        g0 = glog.size(); d0 = dlog.size();
        load(2, 3, 1, 8'hA1);
        wait_idle(100);
        chk("single_owner", 32'(glog[g0]), 32'd2);
        chk("single_beats", 32'(dlog.size() - d0), 32'd3);
        chk("single_a1", 32'(dlog[d0]), 32'hA1);
        chk("single_a2", 32'(dlog[d0+1]), 32'hA2);
        chk("single_a3", 32'(dlog[d0+2]), 32'hA3);

        // stall timeout on owner 1, requester 2 next
        g0 = glog.size(); t0 = to_cnt;
        bus_ready = 1'b0;
        load(1, 3, 1, 8'h50);
        load(2, 1, 1, 8'h60);
        for (int c = 0; c < 40 && to_cnt == t0; c++) tick();
        bus_ready = 1'b1;
        wait_idle(100);
        chk("stall_timeouts", 32'(to_cnt - t0), 32'd1);
        chk("stall_first", 32'(glog[g0]), 32'd1);
        chk("stall_next", 32'(glog[g0+1]), 32'd2);
        chk("stall_regrant", 32'(glog[g0+2]), 32'd1);

        // abandon mid-packet
        t0 = to_cnt; d0 = dlog.size();
        load(0, 4, 1, 8'h70);
        wait_dlog(d0 + 2, 50);
        bus_ready = 1'b0;
        rem[0] = 0;
        repeat (4) tick();
        bus_ready = 1'b1;
        wait_idle(50);
        chk("abandon_no_timeout", 32'(to_cnt - t0), 32'd0);
        chk("abandon_partial", 32'(dlog.size() - d0 < 4), 32'd1);

        // async reset mid-packet, owner 3
        d0 = dlog.size();
        load(3, 4, 1, 8'h80);
        wait_dlog(d0 + 1, 50);
        chk("pre_reset_gnt", 32'(gnt), 32'h8);
        rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_valid", 32'(bus_valid), 32'h0);
        chk("async_data", 32'(bus_data), 32'h0);
        g0 = glog.size();
        repeat (2) tick();
        rst_n = 1'b1;
        wait_idle(100);
        chk("reset_regrant", 32'(glog[g0]), 32'd3);

        // randomized traffic with stall bursts and occasional abandons
        stall_left = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (stall_left > 0) begin
                stall_left--;
                bus_ready = 1'b0;
            end else if ($urandom_range(99) == 0) begin
                stall_left = 18;
                bus_ready  = 1'b0;
            end else begin
                bus_ready = ($urandom_range(3) != 0);
            end
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(3) == 0)
                    load(i, int'($urandom_range(1, 4)), int'($urandom_range(1, 2)), DW'($urandom));
                else if (rem[i] > 0 && $urandom_range(199) == 0)
                    rem[i] = 0;
            end
        end
        bus_ready = 1'b1;
        wait_idle(300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
